// File: rtl/uart_bus_responder.sv
// Slave end of the UART bridge: cmd/addr/data frame in, one bus request out, read byte or ack back.
// req_valid rises 1 clk after the last stop-bit sample; holds until req_ready; bytes arriving while busy are dropped.
module uart_bus_responder #(
  parameter int         ADDR_WIDTH            = 16,
  parameter int         DATA_WIDTH            = 8,
  parameter int         UART_CLOCKS_PER_PULSE = 5208,
  parameter int         FRAME_TIMEOUT_BITS    = 40,
  parameter logic [7:0] WR_ACK_BYTE           = 8'hAC
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  u_rx,
  output logic                  u_tx,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_wen,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CPP     = UART_CLOCKS_PER_PULSE;
  localparam int HALF    = CPP / 2;
  localparam int CW      = $clog2(CPP + 1);
  localparam int TO_CLKS = FRAME_TIMEOUT_BITS * CPP;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam int NA      = (ADDR_WIDTH + 7) / 8;
  localparam logic [7:0] CMD_WR = 8'hA1;
  localparam logic [7:0] CMD_RD = 8'hA0;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
  typedef enum logic [2:0] {F_IDLE, F_ADDR, F_DATA, F_ISSUE, F_WAIT_RSP, F_SEND} f_state_t;

  // ---------------- receiver ----------------
  logic            rx_s1, rx_s2, rx_d;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_done, rx_ferr;
  logic            tick_half, tick_full, rx_active;

  assign tick_half = (rx_cnt == CW'(HALF));
  assign tick_full = (rx_cnt == CW'(CPP));
  assign rx_active = (rx_state inside {R_START, R_DATA, R_STOP});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= u_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:   if (rx_d && !rx_s2) rx_next = R_START;
      R_START:  if (tick_half) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:   if (tick_full && rx_bit == 3'd7) rx_next = R_STOP;
      R_STOP:   if (tick_full) rx_next = rx_s2 ? R_IDLE : R_WAITHI;
      R_WAITHI: if (rx_s2) rx_next = R_IDLE;
      default:  rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      // Counter restarts at each sample point so the next sample lands one bit period later
      if ((rx_state inside {R_IDLE, R_WAITHI}) || (rx_state == R_START && tick_half) ||
          ((rx_state inside {R_DATA, R_STOP}) && tick_full))
        rx_cnt <= CW'(1);
      else
        rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == R_START) rx_bit <= '0;
      if (rx_state == R_DATA && tick_full) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
      if (rx_state == R_STOP && tick_full) begin
        if (rx_s2) rx_done <= 1'b1;
        else       rx_ferr <= 1'b1;
      end
    end
  end

  // ---------------- frame sequencer ----------------
  f_state_t      f_state, f_next;
  logic          f_err, cmd_ok, last_addr, to_hit, tx_last;
  logic [7:0]    addr_hi;
  logic [15:0]   addr_asm;
  logic [1:0]    a_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    tx_data;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_idx;
  logic [CW-1:0] tx_cnt;

  assign cmd_ok    = rx_done && (rx_sh == CMD_WR || rx_sh == CMD_RD);
  assign last_addr = (a_cnt == 2'(NA - 1));
  assign to_hit    = (to_cnt == TW'(TO_CLKS - 1));
  assign tx_last   = (tx_idx == 4'd9) && (tx_cnt == CW'(CPP - 1));
  assign addr_asm  = {addr_hi, rx_sh};
  assign tx_frame  = {1'b1, tx_data, 1'b0};
  assign req_valid = (f_state == F_ISSUE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) f_state <= F_IDLE;
    else       f_state <= f_next;
  end

  always_comb begin
    f_next = f_state;
    f_err  = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (cmd_ok) f_next = F_ADDR;
        f_err = rx_ferr || (rx_done && !cmd_ok);
      end
      F_ADDR: begin
        if (rx_ferr) begin
          f_err  = 1'b1;
          f_next = F_IDLE;
        end else if (rx_done) begin
          if (last_addr) f_next = req_wen ? F_DATA : F_ISSUE;
        end else if (to_hit) begin
          f_err  = 1'b1;
          f_next = F_IDLE;
        end
      end
      F_DATA: begin
        if (rx_ferr || (!rx_done && to_hit)) begin
          f_err  = 1'b1;
          f_next = F_IDLE;
        end else if (rx_done) begin
          f_next = F_ISSUE;
        end
      end
      F_ISSUE: begin
        f_err = rx_done || rx_ferr;
        if (req_ready) f_next = (req_wen || rsp_valid) ? F_SEND : F_WAIT_RSP;
      end
      F_WAIT_RSP: begin
        f_err = rx_done || rx_ferr;
        if (rsp_valid) f_next = F_SEND;
      end
      F_SEND: begin
        f_err = rx_done || rx_ferr;
        if (tx_last) f_next = F_IDLE;
      end
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy      <= 1'b0;
      frame_err <= 1'b0;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      addr_hi   <= '0;
      a_cnt     <= '0;
      to_cnt    <= '0;
      tx_data   <= '0;
      tx_idx    <= '0;
      tx_cnt    <= '0;
      u_tx      <= 1'b1;
    end else begin
      frame_err <= f_err;
      busy      <= (f_next != F_IDLE);
      // Gap timer runs only while the receiver is hunting for the next start bit
      if ((f_state inside {F_ADDR, F_DATA}) && !rx_active && !rx_done)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;
      if (f_state == F_IDLE && cmd_ok) begin
        req_wen <= (rx_sh == CMD_WR);
        a_cnt   <= '0;
        addr_hi <= '0;
      end
      if (f_state == F_ADDR && rx_done) begin
        addr_hi <= rx_sh;
        a_cnt   <= a_cnt + 2'd1;
        if (last_addr) req_addr <= ADDR_WIDTH'(addr_asm);
      end
      if (f_state == F_DATA && rx_done) req_wdata <= DATA_WIDTH'(rx_sh);
      if (f_state == F_ISSUE && req_ready) tx_data <= req_wen ? WR_ACK_BYTE : 8'(rsp_rdata);
      if (f_state == F_WAIT_RSP && rsp_valid) tx_data <= 8'(rsp_rdata);
      if (f_state == F_SEND) begin
        u_tx <= tx_frame[tx_idx];
        if (tx_cnt == CW'(CPP - 1)) begin
          tx_cnt <= '0;
          tx_idx <= tx_idx + 4'd1;
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end else begin
        u_tx   <= 1'b1;
        tx_cnt <= '0;
        tx_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: directed frames in, bus requests and UART replies checked by monitors.
module tb_uart_bus_responder;

  localparam int CPP = 8;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          u_rx;
  logic          u_tx;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          busy, frame_err;

  uart_bus_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .UART_CLOCKS_PER_PULSE(CPP),
    .FRAME_TIMEOUT_BITS(40), .WR_ACK_BYTE(8'hAC)
  ) dut (
    .clk(clk), .rstn(rstn), .u_rx(u_rx), .u_tx(u_tx),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          chk_wdata;
    int            cycles;
  } req_exp_t;

  req_exp_t   exp_req[$];
  logic [7:0] exp_tx[$];
  int vectors = 0, miscompares = 0, err_cnt = 0;
  bit busy_seen = 0, utx_low_seen = 0;
  int ready_delay = 0, rsp_delay = 1;
  logic [7:0] rdata_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus slave: ready after ready_delay valid cycles, read data rsp_delay clks after handshake
  initial begin
    int hc, pend;
    bit prev_hs;
    hc = 0; pend = 0; prev_hs = 0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        hc = 0; pend = 0; prev_hs = 0;
        req_ready = 1'b0; rsp_valid = 1'b0;
      end else begin
        rsp_valid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin rsp_valid = 1'b1; rsp_rdata = rdata_val; end
        end
        if (prev_hs) pend = rsp_delay;
        if (req_valid) begin req_ready = (hc >= ready_delay); hc++; end
        else begin req_ready = 1'b0; hc = 0; end
        prev_hs = req_valid && req_ready && !req_wen;
      end
    end
  end

  // Request monitor
  initial begin
    int vcyc;
    logic [AW-1:0] a0;
    req_exp_t e;
    vcyc = 0; a0 = '0;
    forever begin
      @(negedge clk);
      if (!rstn) vcyc = 0;
      else if (req_valid) begin
        if (vcyc == 0) a0 = req_addr;
        else check("req_addr_stable", req_addr, a0);
        vcyc++;
        if (req_ready) begin
          if (exp_req.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL req_unexpected: got addr %0h wen %0b, required no request", req_addr, req_wen);
          end else begin
            e = exp_req.pop_front();
            check("req_wen", req_wen, e.wen);
            check("req_addr", req_addr, e.addr);
            if (e.chk_wdata) check("req_wdata", req_wdata, e.wdata);
            check("req_valid_cycles", vcyc, e.cycles);
          end
          vcyc = 0;
        end
      end
    end
  end

  // UART TX monitor: samples each bit at its centre
  initial begin
    logic prev, st, sp;
    logic [7:0] d, e;
    bit ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rstn && prev && !u_tx) begin
        ab = 0; st = 1'b0; sp = 1'b0; d = 8'h00;
        for (int k = 0; k < 10; k++) begin
          if (!ab) begin
            repeat ((k == 0) ? 3 : 8) begin
              @(negedge clk);
              if (!rstn) ab = 1;
            end
            if (k == 0) st = u_tx;
            else if (k < 9) d[k-1] = u_tx;
            else sp = u_tx;
          end
        end
        if (!ab) begin
          check("tx_start_bit", st, 0);
          if (exp_tx.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL tx_unexpected: got byte %02h, required none", d);
          end else begin
            e = exp_tx.pop_front();
            check("tx_byte", d, e);
          end
          check("tx_stop_bit", sp, 1);
        end
      end
      prev = u_tx;
    end
  end

  always @(negedge clk) begin
    if (rstn && frame_err) err_cnt++;
    if (busy) busy_seen = 1;
    if (!u_tx) utx_low_seen = 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    u_rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    u_rx = stop;
    repeat (CPP) @(negedge clk);
    if (!stop) begin
      u_rx = 1'b1;
      repeat (2 * CPP) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && exp_req.size() == 0) ok = 1;
    end
    repeat (10) @(negedge clk);
    check({name, "_done"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    bit ok;
    rstn = 1'b0;
    u_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_u_tx", u_tx, 1);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_wen", req_wen, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_wdata", req_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // write, ready tied high
    ready_delay = 0;
    exp_req.push_back('{1'b1, 14'h1234, 8'h5A, 1'b1, 1});
    exp_tx.push_back(8'hAC);
    e0 = err_cnt;
    send_byte(8'hA1); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5A);
    wait_done("t1");
    check("t1_err", err_cnt - e0, 0);

    // read with ready held low 5 clks, data 3 clks after handshake
    ready_delay = 5; rsp_delay = 3; rdata_val = 8'hC3;
    exp_req.push_back('{1'b0, 14'h3FFF, 8'h00, 1'b0, 6});
    exp_tx.push_back(8'hC3);
    e0 = err_cnt;
    send_byte(8'hA0); send_byte(8'h3F); send_byte(8'hFF);
    wait_done("t2");
    check("t2_err", err_cnt - e0, 0);

    // invalid command, then a normal read
    busy_seen = 0; e0 = err_cnt;
    send_byte(8'h77);
    repeat (20) @(negedge clk);
    check("t3_err", err_cnt - e0, 1);
    check("t3_busy_seen", busy_seen, 0);
    check("t3_no_req", exp_req.size(), 0);
    ready_delay = 0; rsp_delay = 1; rdata_val = 8'h96;
    exp_req.push_back('{1'b0, 14'h0102, 8'h00, 1'b0, 1});
    exp_tx.push_back(8'h96);
    e0 = err_cnt;
    send_byte(8'hA0); send_byte(8'h01); send_byte(8'h02);
    wait_done("t3b");
    check("t3b_err", err_cnt - e0, 0);

    // inter-byte timeout, then a write whose address top bits are discarded
    e0 = err_cnt;
    send_byte(8'hA1); send_byte(8'h12);
    check("t4_busy_mid", busy, 1);
    repeat (41 * CPP) @(negedge clk);
    check("t4_err", err_cnt - e0, 1);
    check("t4_busy_after", busy, 0);
    exp_req.push_back('{1'b1, 14'h3FFF, 8'h33, 1'b1, 1});
    exp_tx.push_back(8'hAC);
    e0 = err_cnt;
    send_byte(8'hA1); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h33);
    wait_done("t4b");
    check("t4b_err", err_cnt - e0, 0);

    // framing error on an address byte
    utx_low_seen = 0; e0 = err_cnt;
    send_byte(8'hA1);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("t5_err", err_cnt - e0, 1);
    check("t5_busy", busy, 0);
    check("t5_utx_low_seen", utx_low_seen, 0);

    // reset in the middle of the read reply
    ready_delay = 0; rsp_delay = 3; rdata_val = 8'hC3;
    exp_req.push_back('{1'b0, 14'h3FFF, 8'h00, 1'b0, 1});
    e0 = err_cnt;
    send_byte(8'hA0); send_byte(8'h3F); send_byte(8'hFF);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!u_tx) ok = 1;
    end
    check("t6_tx_started", ok, 1);
    check("t6_err", err_cnt - e0, 0);
    repeat (44) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t6_rst_u_tx", u_tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_valid", req_valid, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rsp_delay = 1;
    exp_req.push_back('{1'b1, 14'h0001, 8'hE7, 1'b1, 1});
    exp_tx.push_back(8'hAC);
    e0 = err_cnt;
    send_byte(8'hA1); send_byte(8'hC0); send_byte(8'h01); send_byte(8'hE7);
    wait_done("t6b");
    check("t6b_err", err_cnt - e0, 0);

    check("end_req_queue", exp_req.size(), 0);
    check("end_tx_queue", exp_tx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
